// File: rtl/arith_pkg.sv
`default_nettype none
// ============================================================================
// Module   : arith_pkg
// Brief    : Shared arithmetic constants, extension width rule and saturation
//            limit helpers for the add/subtract datapath.
// Revision : 1.0 - initial release
// ============================================================================
package arith_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Extension width M: one bit wider than the widest of operands and result.
    function automatic int ext_width(input int aw, input int bw, input int sw);
        int m;
        m = (aw > bw) ? aw : bw;
        m = (m > sw) ? m : sw;
        return m + 1;
    endfunction

    // Limits are returned in 64 bits; callers keep the low w bits.
    function automatic logic [63:0] sat_max(input int w, input logic is_sgn);
        return is_sgn ? ((64'd1 << (w - 1)) - 64'd1) : ((64'd1 << w) - 64'd1);
    endfunction

    function automatic logic [63:0] sat_min(input int w, input logic is_sgn);
        return is_sgn ? ~((64'd1 << (w - 1)) - 64'd1) : 64'd0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_slice.sv
`default_nettype none
// ============================================================================
// Module   : pipe_slice
// Brief    : Parametrised-width valid/ready register slice; holds while stalled.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_slice #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         r_valid;
    logic [W-1:0] r_data;
    logic         w_load;

    assign w_load = !r_valid || out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (w_load) begin
            r_valid <= in_valid;
            if (in_valid) begin
                r_data <= in_data;
            end
        end
    end

    assign out_valid = r_valid;
    assign out_data  = r_data;

endmodule
`default_nettype wire

// File: rtl/generic_addsub_pipe.sv
`default_nettype none
// ============================================================================
// Module   : generic_addsub_pipe
// Brief    : Pipelined signed/unsigned add/subtract with optional saturation,
//            valid/ready flow control and a saturating overflow event counter.
// Revision : 1.0 - initial release
// ============================================================================
module generic_addsub_pipe
    import arith_pkg::*;
#(
    parameter int AW       = 21,
    parameter int BW       = 21,
    parameter int SW       = 22,
    parameter int STAGES   = 2,
    parameter int SATURATE = 0,
    parameter int CNTW     = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [AW-1:0]   a,
    input  logic [BW-1:0]   b,
    input  logic            op_sub,
    input  logic            is_signed,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [SW-1:0]   result,
    output logic            overflow,
    output logic [CNTW-1:0] ovf_count,
    input  logic            ovf_clear
);

    // One guard bit above M lets unsigned sums and differences share a signed view.
    localparam int c_fw = ext_width(AW, BW, SW) + 1;

    localparam logic [63:0]   c_umax_w = sat_max(SW, 1'b0);
    localparam logic [63:0]   c_smax_w = sat_max(SW, 1'b1);
    localparam logic [63:0]   c_umin_w = sat_min(SW, 1'b0);
    localparam logic [63:0]   c_smin_w = sat_min(SW, 1'b1);
    localparam logic [SW-1:0] c_umax   = c_umax_w[SW-1:0];
    localparam logic [SW-1:0] c_smax   = c_smax_w[SW-1:0];
    localparam logic [SW-1:0] c_umin   = c_umin_w[SW-1:0];
    localparam logic [SW-1:0] c_smin   = c_smin_w[SW-1:0];

    logic [c_fw-1:0]  w_a_ext;
    logic [c_fw-1:0]  w_b_ext;
    logic [c_fw-1:0]  w_full;
    logic [c_fw-SW:0] w_hi;
    logic             w_neg;
    logic             w_ovf;
    logic [SW-1:0]    w_sat;
    logic [SW-1:0]    w_res;

    logic [STAGES-1:0] w_vld;
    logic [STAGES:0]   w_rdy;
    logic [SW:0]       w_data [STAGES];

    logic              r_s1_valid;
    logic [SW:0]       r_s1_data;
    logic [CNTW-1:0]   r_cnt;
    logic              w_ovf_xfer;

    assign w_a_ext = is_signed ? {{(c_fw-AW){a[AW-1]}}, a} : {{(c_fw-AW){1'b0}}, a};
    assign w_b_ext = is_signed ? {{(c_fw-BW){b[BW-1]}}, b} : {{(c_fw-BW){1'b0}}, b};
    assign w_full  = (op_sub == OP_SUB) ? (w_a_ext - w_b_ext) : (w_a_ext + w_b_ext);

    // Fits signed SW bits iff bits [c_fw-1:SW-1] are all equal; unsigned iff [c_fw-1:SW] are zero.
    assign w_hi  = w_full[c_fw-1:SW-1];
    assign w_neg = w_full[c_fw-1];
    assign w_ovf = is_signed ? !((&w_hi) || !(|w_hi)) : (|w_full[c_fw-1:SW]);
    assign w_sat = w_neg ? (is_signed ? c_smin : c_umin) : (is_signed ? c_smax : c_umax);
    assign w_res = ((SATURATE != 0) && w_ovf) ? w_sat : w_full[SW-1:0];

    // Stage i may load when it is empty or anything downstream can move.
    always_comb begin
        w_rdy[STAGES] = out_ready;
        for (int i = STAGES - 1; i >= 0; i--) begin
            w_rdy[i] = w_rdy[i+1] || !w_vld[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_data  <= '0;
        end else if (w_rdy[0]) begin
            r_s1_valid <= in_valid;
            if (in_valid) begin
                r_s1_data <= {w_ovf, w_res};
            end
        end
    end

    assign in_ready  = w_rdy[0];
    assign w_vld[0]  = r_s1_valid;
    assign w_data[0] = r_s1_data;

    for (genvar gi = 1; gi < STAGES; gi++) begin : g_slice
        pipe_slice #(
            .W(SW + 1)
        ) u_slice (
            .clk      (clk),
            .rst_n    (rst_n),
            .in_valid (w_vld[gi-1]),
            .in_data  (w_data[gi-1]),
            .out_valid(w_vld[gi]),
            .out_ready(w_rdy[gi+1]),
            .out_data (w_data[gi])
        );
    end

    assign out_valid          = w_vld[STAGES-1];
    assign {overflow, result} = w_data[STAGES-1];

    assign w_ovf_xfer = out_valid && out_ready && overflow;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (ovf_clear) begin
            r_cnt <= '0;
        end else if (w_ovf_xfer && (r_cnt != {CNTW{1'b1}})) begin
            r_cnt <= r_cnt + CNTW'(1);
        end
    end

    assign ovf_count = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_generic_addsub_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_generic_addsub_pipe
// Brief    : Self-checking bench for generic_addsub_pipe (wrap and saturate builds).
// Revision : 1.0 - initial release
// ============================================================================
module tb_generic_addsub_pipe;

    localparam int AW  = 21;
    localparam int BW  = 21;
    localparam int SW  = 22;
    localparam int ST  = 2;
    localparam int W2  = 8;
    localparam int ST2 = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Wrapping build, default geometry
    logic          rst_n1, in_valid1, in_ready1, sub1, sgn1, out_valid1, out_ready1, ovf1, clr1;
    logic [AW-1:0] a1;
    logic [BW-1:0] b1;
    logic [SW-1:0] result1;
    logic [15:0]   cnt1;

    // Saturating 8-bit build with a tiny counter
    logic          rst_n2, in_valid2, in_ready2, sub2, sgn2, out_valid2, out_ready2, ovf2, clr2;
    logic [W2-1:0] a2, b2, result2;
    logic [1:0]    cnt2;

    generic_addsub_pipe #(
        .AW(AW), .BW(BW), .SW(SW), .STAGES(ST), .SATURATE(0), .CNTW(16)
    ) dut1 (
        .clk(clk), .rst_n(rst_n1), .in_valid(in_valid1), .in_ready(in_ready1),
        .a(a1), .b(b1), .op_sub(sub1), .is_signed(sgn1),
        .out_valid(out_valid1), .out_ready(out_ready1), .result(result1),
        .overflow(ovf1), .ovf_count(cnt1), .ovf_clear(clr1)
    );

    generic_addsub_pipe #(
        .AW(W2), .BW(W2), .SW(W2), .STAGES(ST2), .SATURATE(1), .CNTW(2)
    ) dut2 (
        .clk(clk), .rst_n(rst_n2), .in_valid(in_valid2), .in_ready(in_ready2),
        .a(a2), .b(b2), .op_sub(sub2), .is_signed(sgn2),
        .out_valid(out_valid2), .out_ready(out_ready2), .result(result2),
        .overflow(ovf2), .ovf_count(cnt2), .ovf_clear(clr2)
    );

    int n_checks = 0;
    int n_errs   = 0;
    int tx = 0;
    int rx = 0;
    int model_cnt = 0;
    logic [SW:0] expq [$];

    typedef struct {
        logic [AW-1:0] a;
        logic [BW-1:0] b;
        bit            sub;
        bit            sgn;
        logic [SW-1:0] res;
        bit            ovf;
    } vec_t;
    vec_t tbl [7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: exact integer arithmetic, then range test against the result format.
    function automatic void model(input logic [63:0] a, input logic [63:0] b, input bit sub,
                                  input bit sgn, input int aw, input int bw, input int sw,
                                  input bit sat, output logic [63:0] res, output bit ovf);
        longint av, bv, full, lo, hi;
        av = longint'(a & ((64'd1 << aw) - 64'd1));
        bv = longint'(b & ((64'd1 << bw) - 64'd1));
        if (sgn && a[aw-1]) av = av - (longint'(1) << aw);
        if (sgn && b[bw-1]) bv = bv - (longint'(1) << bw);
        full = sub ? (av - bv) : (av + bv);
        lo   = sgn ? -(longint'(1) << (sw - 1)) : 0;
        hi   = sgn ? ((longint'(1) << (sw - 1)) - 1) : ((longint'(1) << sw) - 1);
        ovf  = (full < lo) || (full > hi);
        if (ovf && sat) full = (full < lo) ? lo : hi;
        res = 64'(full) & ((64'd1 << sw) - 64'd1);
    endfunction

    // One cycle on dut1: drive, score any out/in transfer, advance to just past the edge.
    task automatic step1(input bit iv, input logic [AW-1:0] a, input logic [BW-1:0] b,
                         input bit sub, input bit sgn, input bit ordy);
        logic [63:0] mr;
        bit          mo;
        logic [SW:0] e;
        in_valid1 = iv; a1 = a; b1 = b; sub1 = sub; sgn1 = sgn; out_ready1 = ordy;
        #1;
        if (out_valid1 && out_ready1) begin
            if (expq.size() == 0) begin
                n_checks++;
                n_errs++;
                $display("FAIL stream_extra: got result 0x%0h, expected no output", result1);
            end else begin
                e = expq.pop_front();
                chk("stream_res", 64'(result1), 64'(e[SW-1:0]));
                chk("stream_ovf", 64'(ovf1), 64'(e[SW]));
                if (e[SW] && model_cnt < 65535) model_cnt++;
            end
            rx++;
        end
        if (iv && in_ready1) begin
            model(64'(a), 64'(b), sub, sgn, AW, BW, SW, 1'b0, mr, mo);
            expq.push_back({mo, mr[SW-1:0]});
            tx++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic xact2(input string nm, input logic [W2-1:0] a, input logic [W2-1:0] b,
                         input bit sub, input bit sgn, input logic [W2-1:0] er, input bit eo);
        in_valid2 = 1'b1; a2 = a; b2 = b; sub2 = sub; sgn2 = sgn;
        @(posedge clk);
        #1;
        in_valid2 = 1'b0;
        repeat (ST2 - 1) begin
            chk({nm, "_early"}, 64'(out_valid2), 64'd0);
            @(posedge clk);
            #1;
        end
        chk({nm, "_valid"}, 64'(out_valid2), 64'd1);
        chk({nm, "_res"}, 64'(result2), 64'(er));
        chk({nm, "_ovf"}, 64'(ovf2), 64'(eo));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #900000;
        $display("FAIL timeout: simulation did not finish, errors=%0d", n_errs);
        $fatal(1);
    end

    initial begin
        int guard;
        tbl[0] = '{21'd100,      21'd30,       1'b1, 1'b0, 22'd70,       1'b0};
        tbl[1] = '{21'd5,        21'd9,        1'b1, 1'b0, 22'h3FFFFC,   1'b1};
        tbl[2] = '{21'h1FFFFF,   21'h1FFFFF,   1'b0, 1'b0, 22'h3FFFFE,   1'b0};
        tbl[3] = '{21'h1FFFFF,   21'h1FFFFF,   1'b0, 1'b1, 22'h3FFFFE,   1'b0};
        tbl[4] = '{21'h100000,   21'h0FFFFF,   1'b1, 1'b1, 22'h200001,   1'b0};
        tbl[5] = '{21'h000000,   21'h1FFFFF,   1'b1, 1'b0, 22'h200001,   1'b1};
        tbl[6] = '{21'h0FFFFF,   21'h100000,   1'b1, 1'b1, 22'h1FFFFF,   1'b0};

        rst_n1 = 1'b0; in_valid1 = 1'b0; a1 = '0; b1 = '0; sub1 = 1'b0; sgn1 = 1'b0;
        out_ready1 = 1'b1; clr1 = 1'b0;
        rst_n2 = 1'b0; in_valid2 = 1'b0; a2 = '0; b2 = '0; sub2 = 1'b0; sgn2 = 1'b0;
        out_ready2 = 1'b1; clr2 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n1 = 1'b1;
        rst_n2 = 1'b1;
        #1;
        chk("rst_out_valid", 64'(out_valid1), 64'd0);
        chk("rst_result",    64'(result1),    64'd0);
        chk("rst_overflow",  64'(ovf1),       64'd0);
        chk("rst_count",     64'(cnt1),       64'd0);
        chk("rst_in_ready",  64'(in_ready1),  64'd1);
        chk("rst_in_ready2", 64'(in_ready2),  64'd1);
        @(posedge clk);
        #1;

        // Directed vectors on the wrapping build, one at a time
        for (int i = 0; i < 7; i++) begin
            in_valid1 = 1'b1; a1 = tbl[i].a; b1 = tbl[i].b; sub1 = tbl[i].sub; sgn1 = tbl[i].sgn;
            @(posedge clk);
            #1;
            in_valid1 = 1'b0;
            chk("tbl_latency_early", 64'(out_valid1), 64'd0);
            @(posedge clk);
            #1;
            chk("tbl_valid", 64'(out_valid1), 64'd1);
            chk("tbl_res",   64'(result1),    64'(tbl[i].res));
            chk("tbl_ovf",   64'(ovf1),       64'(tbl[i].ovf));
        end
        @(posedge clk);
        #1;
        chk("tbl_count", 64'(cnt1), 64'd2);
        chk("tbl_drained", 64'(out_valid1), 64'd0);

        // Saturating build: clamp both directions, counter sticks at 3
        xact2("s_add_pos",   8'd100,  8'd100, 1'b0, 1'b1, 8'h7F, 1'b1);
        xact2("s_add_neg",   8'h9C,   8'h9C,  1'b0, 1'b1, 8'h80, 1'b1);
        chk("sat_count2", 64'(cnt2), 64'd2);
        xact2("u_sub_under", 8'd5,    8'd9,   1'b1, 1'b0, 8'h00, 1'b1);
        xact2("s_sub_fit",   8'h9C,   8'd27,  1'b1, 1'b1, 8'h81, 1'b0);
        xact2("u_add_over",  8'd200,  8'd100, 1'b0, 1'b0, 8'hFF, 1'b1);
        chk("sat_count_sticky", 64'(cnt2), 64'd3);

        // Clear coincident with an overflowed out transfer
        out_ready2 = 1'b0;
        in_valid2 = 1'b1; a2 = 8'd100; b2 = 8'd100; sub2 = 1'b0; sgn2 = 1'b1;
        @(posedge clk);
        #1;
        in_valid2 = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        chk("clr_pre_valid", 64'(out_valid2), 64'd1);
        chk("clr_pre_ovf",   64'(ovf2),       64'd1);
        clr2 = 1'b1;
        out_ready2 = 1'b1;
        @(posedge clk);
        #1;
        clr2 = 1'b0;
        chk("clr_wins", 64'(cnt2), 64'd0);
        chk("clr_consumed", 64'(out_valid2), 64'd0);

        // Back-pressure: 10 pairs with out_ready low for 5 cycles
        tx = 0; rx = 0; model_cnt = 2;
        for (int c = 0; c < 5; c++) begin
            step1(tx < 10, AW'(1000 + tx * 7), BW'(tx), 1'b0, 1'b0, 1'b0);
            if (c >= 1) begin
                chk("bp_hold_valid", 64'(out_valid1), 64'd1);
                chk("bp_hold_res",   64'(result1),    64'd1000);
            end
        end
        chk("bp_accepts", 64'(tx), 64'(ST));
        chk("bp_in_ready_low", 64'(in_ready1), 64'd0);
        out_ready1 = 1'b1;
        #1;
        chk("bp_in_ready_same_cycle", 64'(in_ready1), 64'd1);
        guard = 0;
        while (rx < 10 && guard < 200) begin
            step1(tx < 10, AW'(1000 + tx * 7), BW'(tx), 1'b0, 1'b0, 1'b1);
            guard++;
        end
        chk("bp_rx", 64'(rx), 64'd10);
        chk("bp_tx", 64'(tx), 64'd10);
        chk("bp_count", 64'(cnt1), 64'(model_cnt));

        // Reset with two overflowing entries in flight
        step1(1'b1, AW'(0), BW'(5), 1'b1, 1'b0, 1'b0);
        step1(1'b1, AW'(0), BW'(5), 1'b1, 1'b0, 1'b0);
        chk("mid_rst_inflight", 64'(out_valid1), 64'd1);
        rst_n1 = 1'b0;
        #3;
        rst_n1 = 1'b1;
        #1;
        chk("mid_rst_out_valid", 64'(out_valid1), 64'd0);
        chk("mid_rst_count",     64'(cnt1),       64'd0);
        chk("mid_rst_in_ready",  64'(in_ready1),  64'd1);
        expq.delete();
        tx = 0; rx = 0; model_cnt = 0;

        // Random valid/ready, operands and per-transaction mode
        guard = 0;
        while (tx < 1000 && guard < 20000) begin
            logic [AW-1:0] ra, rb;
            int sa, sb;
            sa = int'($urandom_range(0, 3));
            sb = int'($urandom_range(0, 3));
            ra = (sa == 0) ? AW'(21'h0FFFFF) : (sa == 1) ? AW'(21'h100000) : AW'($urandom);
            rb = (sb == 0) ? BW'(21'h1FFFFF) : (sb == 1) ? BW'(0) : BW'($urandom);
            step1($urandom_range(0, 9) < 7, ra, rb, 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), $urandom_range(0, 9) < 7);
            guard++;
        end
        guard = 0;
        while (rx < tx && guard < 100) begin
            step1(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
            guard++;
        end
        chk("rand_tx", 64'(tx), 64'd1000);
        chk("rand_rx", 64'(rx), 64'(tx));
        chk("rand_count", 64'(cnt1), 64'(model_cnt));

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
